// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/update sequencer driving the PC.
// Fetches at pc over req/ack, hands the instruction to execute, then pulses one PC update.
module fetch_sequencer #(
    parameter int         ADDR_W  = 32,
    parameter int         INSTR_W = 32,
    parameter logic [5:0] OP_BEQ  = 6'h04,
    parameter logic [5:0] OP_JMP  = 6'h02,
    parameter logic [5:0] OP_BNE  = 6'h05,
    parameter logic [5:0] OP_HALT = 6'h3F,
    parameter int         TIMEOUT = 255,
    parameter int         CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               exec_valid,
    input  logic               exec_done,
    output logic               pc_clk_en,
    output logic [1:0]         pcsel,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALTED, FAULT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic [5:0]    op_ack, op_cur;
    logic [1:0]    sel_dec;

    assign imem_addr = pc;
    assign op_ack    = imem_data[INSTR_W-1 -: 6];
    assign op_cur    = instr[INSTR_W-1 -: 6];

    always_comb begin
        sel_dec = 2'b00;
        if (op_cur == OP_BEQ)      sel_dec = 2'b01;
        else if (op_cur == OP_JMP) sel_dec = 2'b10;
        else if (op_cur == OP_BNE) sel_dec = 2'b11;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // imem_req is high exactly in FETCH, so ack is only looked at there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH: begin
                if (imem_ack)                    state_nxt = (op_ack == OP_HALT) ? HALTED : EXEC;
                else if (tcnt == TW'(TIMEOUT-1)) state_nxt = FAULT;
            end
            EXEC:    if (exec_done) state_nxt = UPDATE;
            UPDATE:  state_nxt = FETCH;
            HALTED:  state_nxt = HALTED;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                tcnt <= '0;
        else if (state != FETCH) tcnt <= '0;
        else if (!imem_ack)      tcnt <= tcnt + TW'(1);
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_req   <= 1'b0;
            instr      <= '0;
            exec_valid <= 1'b0;
            pc_clk_en  <= 1'b0;
            pcsel      <= 2'b00;
            halted     <= 1'b0;
            fault      <= 1'b0;
            retired    <= '0;
        end else begin
            imem_req   <= (state_nxt == FETCH);
            exec_valid <= (state == FETCH) && (state_nxt == EXEC);
            pc_clk_en  <= (state_nxt == UPDATE);
            pcsel      <= (state_nxt == UPDATE) ? sel_dec : 2'b00;
            if ((state == FETCH) && imem_ack) instr <= imem_data;
            if (state_nxt == HALTED) halted <= 1'b1;
            if (state_nxt == FAULT)  fault  <= 1'b1;
            if (state == UPDATE)     retired <= retired + CNT_W'(1);
        end
    end

endmodule
